// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, buffer entry layout, NOP encoding.
package instr_fetch_pkg;

    localparam int unsigned IF_XLEN = 32;
    localparam int unsigned IF_ILEN = 32;

    // Instruction substituted for a misaligned-fetch marker entry (addi x0, x0, 0).
    localparam logic [IF_ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RSP,
        DROP
    } fetch_state_e;

    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [IF_ILEN-1:0] instr;
        logic               misalign;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: PC handshake, instruction-memory port and decode-side valid/ready.
// master = fetch stage, slave = surrounding environment (PC, memory, decode).
interface instr_fetch_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ILEN = 32
);
    logic [XLEN-1:0] pc_in;
    logic            pc_en;
    logic            flush;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [ILEN-1:0] if_instr;
    logic            if_misalign;

    modport master (
        input  pc_in, flush, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        output pc_en, imem_req, imem_addr, if_valid, if_pc, if_instr, if_misalign
    );

    modport slave (
        output pc_in, flush, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        input  pc_en, imem_req, imem_addr, if_valid, if_pc, if_instr, if_misalign
    );
endinterface

// File: rtl/instr_fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; head is the entry at the read pointer.
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  fetch_entry_t  i_entry,
    input  logic          i_pop,
    input  logic          i_flush,
    output fetch_entry_t  o_head,
    output logic [CW-1:0] o_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_FULL) || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Pointer and occupancy tracking; flush wins over any coincident push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage, cleared on reset so the head reads zero before any push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one outstanding imem read at a time, buffers {pc, instr}
// pairs and presents them to decode; drives the ProgramCounter enable.
// Optional build macro: IF_MISALIGN_CHK_EN (misaligned PCs become marker entries, no read issued).
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ILEN      = 32,
    parameter int unsigned BUF_DEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    instr_fetch_if.master bus
);

    localparam int unsigned   CW      = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(BUF_DEPTH);
    localparam logic [CW:0]   CNT_ONE = (CW + 1)'(1);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_req_pc;
    fetch_entry_t    r_hold;

    logic [CW-1:0]   w_count;
    logic [CW:0]     w_cnt_ext;
    logic            w_space;
    logic            w_misalign;
    logic            w_req;
    logic            w_grant;
    logic            w_mis_push;
    logic            w_rsp_push;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;
    fetch_entry_t    w_out;

    assign w_cnt_ext = {1'b0, w_count};

`ifdef IF_MISALIGN_CHK_EN
    assign w_misalign = (r_state == IDLE) && (bus.pc_in[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Buffer space available for a new request; the rvalid cycle in WAIT_RSP must leave room
    // for the response landing now plus the one being requested, without counting a pop.
    always_comb begin
        w_space = 1'b0;
        case (r_state)
            IDLE:     w_space = (w_cnt_ext < DEPTH_W);
            WAIT_RSP: w_space = bus.imem_rvalid && ((w_cnt_ext + CNT_ONE) < DEPTH_W);
            default:  w_space = 1'b0;
        endcase
    end

    // Next-state, request and push decisions.
    always_comb begin
        w_req       = 1'b0;
        w_mis_push  = 1'b0;
        w_rsp_push  = 1'b0;
        w_state_nxt = r_state;
        if (!rst && !bus.flush && w_space) begin
            if (w_misalign) begin
                w_mis_push = 1'b1;
            end else begin
                w_req = 1'b1;
            end
        end
        w_grant = w_req && bus.imem_gnt;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state_nxt = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (bus.imem_rvalid) begin
                    if (bus.flush) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_rsp_push  = 1'b1;
                        w_state_nxt = w_grant ? WAIT_RSP : IDLE;
                    end
                end else if (bus.flush) begin
                    w_state_nxt = DROP;
                end
            end
            DROP: begin
                if (bus.imem_rvalid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the PC of the read accepted this cycle so its response can be tagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_pc <= '0;
        end else if (w_grant) begin
            r_req_pc <= bus.pc_in;
        end
    end

    always_comb begin
        w_push_entry = '0;
        if (w_mis_push) begin
            w_push_entry.pc       = bus.pc_in;
            w_push_entry.instr    = NOP_INSTR;
            w_push_entry.misalign = 1'b1;
        end else begin
            w_push_entry.pc       = r_req_pc;
            w_push_entry.instr    = bus.imem_rdata;
            w_push_entry.misalign = 1'b0;
        end
    end

    assign w_push  = w_mis_push || w_rsp_push;
    assign w_valid = (w_count != '0);
    assign w_pop   = w_valid && bus.if_ready;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (bus.flush),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Decode-side outputs keep showing the last head while the buffer is empty; the FIFO
    // slot under the read pointer is stale at that point, hence the separate hold register.
    assign w_out = w_valid ? w_head : r_hold;

    // Remember whatever is currently presented so it can be held across empty cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
        end else begin
            r_hold <= w_out;
        end
    end

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = bus.pc_in;
    assign bus.pc_en       = !rst && (w_grant || bus.flush || w_mis_push);
    assign bus.if_valid    = w_valid;
    assign bus.if_pc       = w_out.pc;
    assign bus.if_instr    = w_out.instr;
    assign bus.if_misalign = w_out.misalign;

endmodule
